// File: rtl/rotation_cmd_sequencer.sv
// rotation_cmd_sequencer: turns ASCII L/R rotation commands into signed coprocessor deltas and streams results back
// clk_slow, rst           : clock (rising edge) and synchronous active-high reset
// rx_data, rx_valid       : ASCII byte strobe from the UART receiver
// cp_din, cp_din_valid    : delta word and one-cycle issue strobe to the coprocessor
// cp_ctrl, cp_dout        : coprocessor output-mux select and result bus
// tx_data, tx_valid, tx_ready : result bytes to the UART transmitter, MSB first
// busy, err               : command in flight (beyond parsing) and sticky protocol error
module rotation_cmd_sequencer #(
    parameter int WIDTH_DIN = 128,
    parameter int WIDTH_COMPUTE = 32,
    parameter int MAX_DIGITS = 4
) (
    input  logic                 clk_slow,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [WIDTH_DIN-1:0] cp_din,
    output logic                 cp_din_valid,
    output logic [2:0]           cp_ctrl,
    input  logic [WIDTH_DIN-1:0] cp_dout,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 err
);
    localparam int NB = WIDTH_COMPUTE / 8;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int IW = $clog2(NB + 1);
    typedef enum logic [3:0] {IDLE, DIGITS, ISSUE, SKIP, FLUSH1, GAP, FLUSH2, SELECT, TX} state_t;
    state_t st, nxt;
    logic [WIDTH_COMPUTE-1:0] mag, result, sval, shifted;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic dir, set_err, is_digit, is_dir, is_eol, room;
    logic unused_dout;
    assign is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
    assign is_dir = rx_data == 8'h4C || rx_data == 8'h52;
    assign is_eol = rx_data == 8'h0A || rx_data == 8'h0D;
    assign room = cnt != CW'(MAX_DIGITS);
    assign sval = dir ? -mag : mag;
    // the byte being sent is always moved to the top of the word
    assign shifted = result << {idx, 3'b000};
    assign unused_dout = ^cp_dout[WIDTH_DIN-1:WIDTH_COMPUTE];
    assign busy = !(st == IDLE || st == DIGITS);
    assign cp_din_valid = st == ISSUE || st == FLUSH1 || st == FLUSH2;
    assign cp_din = st == ISSUE ? {{(WIDTH_DIN-WIDTH_COMPUTE){sval[WIDTH_COMPUTE-1]}}, sval} : '0;
    assign cp_ctrl = (st == SELECT || st == TX) ? 3'b100 : 3'b000;
    assign tx_valid = st == TX;
    assign tx_data = tx_valid ? shifted[WIDTH_COMPUTE-1 -: 8] : 8'h00;
    always_ff @(posedge clk_slow)
        st <= rst ? IDLE : nxt;
    always_comb begin
        nxt = st;
        set_err = 1'b0;
        case (st)
            IDLE: if (rx_valid) begin
                if (is_dir) nxt = DIGITS;
                else if (rx_data == 8'h3D) nxt = FLUSH1;
                else if (!is_eol) begin
                    set_err = 1'b1;
                    nxt = SKIP;
                end
            end
            DIGITS: if (rx_valid && rx_data != 8'h0D) begin
                if (is_digit && room) nxt = DIGITS;
                else if (rx_data == 8'h0A && cnt != '0) nxt = ISSUE;
                else begin
                    set_err = 1'b1;
                    nxt = rx_data == 8'h0A ? IDLE : SKIP;
                end
            end
            ISSUE:  nxt = IDLE;
            SKIP:   nxt = (rx_valid && rx_data == 8'h0A) ? IDLE : SKIP;
            FLUSH1: nxt = GAP;
            GAP:    nxt = FLUSH2;
            FLUSH2: nxt = SELECT;
            SELECT: nxt = TX;
            TX:     nxt = (tx_ready && idx == IW'(NB - 1)) ? IDLE : TX;
            default: nxt = IDLE;
        endcase
        // SKIP is busy but consumes bytes silently while hunting for the line end
        if (rx_valid && busy && st != SKIP) set_err = 1'b1;
    end
    always_ff @(posedge clk_slow) begin
        if (rst) begin
            mag <= '0;
            cnt <= '0;
            dir <= 1'b0;
            result <= '0;
            idx <= '0;
            err <= 1'b0;
        end else begin
            err <= err | set_err;
            if (st == IDLE && rx_valid && is_dir) begin
                dir <= rx_data == 8'h4C;
                mag <= '0;
                cnt <= '0;
            end
            if (st == DIGITS && rx_valid && is_digit && room) begin
                mag <= mag * WIDTH_COMPUTE'(10) + WIDTH_COMPUTE'(rx_data[3:0]);
                cnt <= cnt + CW'(1);
            end
            if (st == SELECT) begin
                result <= cp_dout[WIDTH_COMPUTE-1:0];
                idx <= '0;
            end
            if (st == TX && tx_ready) idx <= idx + IW'(1);
        end
    end
endmodule
